// File: rtl/had_jdb_req_ctrl_if.sv
// JDB debug-request handshake bundle between the pad/core side and had_jdb_req_ctrl.
// master drives the pad/core/control inputs; slave is the controller.
interface had_jdb_req_ctrl_if;
    logic pad_had_jdb_req_b;
    logic iu_yy_xx_dbgon;
    logic had_jdb_ctrl_en;
    logic had_jdb_abort;
    logic had_iu_jdb_dbgreq;
    logic had_pad_jdb_ack_b;
    logic had_jdb_busy;
    logic had_jdb_timeout;

    modport master (
        output pad_had_jdb_req_b,
        output iu_yy_xx_dbgon,
        output had_jdb_ctrl_en,
        output had_jdb_abort,
        input  had_iu_jdb_dbgreq,
        input  had_pad_jdb_ack_b,
        input  had_jdb_busy,
        input  had_jdb_timeout
    );

    modport slave (
        input  pad_had_jdb_req_b,
        input  iu_yy_xx_dbgon,
        input  had_jdb_ctrl_en,
        input  had_jdb_abort,
        output had_iu_jdb_dbgreq,
        output had_pad_jdb_ack_b,
        output had_jdb_busy,
        output had_jdb_timeout
    );
endinterface

// File: rtl/had_jdb_req_ctrl.sv
// JDB debug-request sequencer in the tclk domain: sync + glitch filter, core request, pad ack.
// Optional REQ watchdog / ERR state / sticky timeout flag enabled by HAD_JDB_TIMEOUT_EN.
module had_jdb_req_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYC    = 4,
    parameter int unsigned TO_CYC      = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 tclk,
    input  logic                 trst_b,
    had_jdb_req_ctrl_if.slave    jdb
);

`ifdef HAD_JDB_TIMEOUT_EN
    localparam int unsigned CNT_NEED = (FILT_CYC > TO_CYC) ? FILT_CYC : TO_CYC;
`else
    localparam int unsigned CNT_NEED = FILT_CYC;
`endif

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("had_jdb_req_ctrl: SYNC_STAGES must be at least 2");
        end
        if (FILT_CYC < 1 || TO_CYC < 1) begin : g_bad_cyc
            $error("had_jdb_req_ctrl: FILT_CYC and TO_CYC must be at least 1");
        end
        if (CNT_W < 32 && ((CNT_NEED - 1) >> CNT_W) != 0) begin : g_bad_cnt
            $error("had_jdb_req_ctrl: CNT_W too narrow for the filter/timeout count");
        end
    endgenerate

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYC - 1);
`ifdef HAD_JDB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILT,
        ST_REQ,
        ST_ACK,
        ST_WAIT_REL
`ifdef HAD_JDB_TIMEOUT_EN
        , ST_ERR
`endif
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_dbgreq;
    logic                   r_ack_b;
    logic                   r_busy;
`ifdef HAD_JDB_TIMEOUT_EN
    logic                   w_to_set;
    logic                   r_timeout;
`endif

    always_ff @(posedge tclk or negedge trst_b) begin
        if (!trst_b) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], jdb.pad_had_jdb_req_b};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    // Abort/disable only cut short the states that have not yet touched the pad handshake.
    always_comb begin
        w_state_nxt = r_state;
`ifdef HAD_JDB_TIMEOUT_EN
        w_to_set    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (jdb.had_jdb_ctrl_en && !w_req_s) w_state_nxt = ST_FILT;
            end
            ST_FILT: begin
                if (jdb.had_jdb_abort || !jdb.had_jdb_ctrl_en || w_req_s) w_state_nxt = ST_IDLE;
                else if (r_cnt == FILT_LAST)                              w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (jdb.had_jdb_abort || !jdb.had_jdb_ctrl_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (jdb.iu_yy_xx_dbgon) begin
                    w_state_nxt = ST_ACK;
                end
`ifdef HAD_JDB_TIMEOUT_EN
                else if (r_cnt == TO_LAST) begin
                    w_state_nxt = ST_ERR;
                    w_to_set    = 1'b1;
                end
`endif
            end
            ST_ACK: begin
                if (w_req_s) w_state_nxt = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!jdb.iu_yy_xx_dbgon) w_state_nxt = ST_IDLE;
            end
`ifdef HAD_JDB_TIMEOUT_EN
            ST_ERR: begin
                if (jdb.had_jdb_abort || !jdb.had_jdb_ctrl_en || w_req_s) w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter restarts on every state change; only FILT (and REQ with the watchdog) count.
    always_comb begin
        w_cnt_nxt = '0;
        if (w_state_nxt == r_state) begin
            if (r_state == ST_FILT) w_cnt_nxt = r_cnt + 1'b1;
`ifdef HAD_JDB_TIMEOUT_EN
            if (r_state == ST_REQ)  w_cnt_nxt = r_cnt + 1'b1;
`endif
        end
    end

    always_ff @(posedge tclk or negedge trst_b) begin
        if (!trst_b) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_dbgreq <= 1'b0;
            r_ack_b  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dbgreq <= (w_state_nxt == ST_REQ);
            r_ack_b  <= (w_state_nxt != ST_ACK);
            r_busy   <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef HAD_JDB_TIMEOUT_EN
    // Abort clears the flag and, in REQ, also suppresses a same-cycle timeout set.
    always_ff @(posedge tclk or negedge trst_b) begin
        if (!trst_b) begin
            r_timeout <= 1'b0;
        end else if (jdb.had_jdb_abort) begin
            r_timeout <= 1'b0;
        end else if (w_to_set) begin
            r_timeout <= 1'b1;
        end
    end

    assign jdb.had_jdb_timeout = r_timeout;
`else
    assign jdb.had_jdb_timeout = 1'b0;
`endif

    assign jdb.had_iu_jdb_dbgreq = r_dbgreq;
    assign jdb.had_pad_jdb_ack_b = r_ack_b;
    assign jdb.had_jdb_busy      = r_busy;

endmodule

// File: tb/tb_had_jdb_req_ctrl.sv
// Bench for had_jdb_req_ctrl: timed directed scenarios plus random traffic against a phase model.
// Honours HAD_JDB_TIMEOUT_EN the same way as the design.
module tb_had_jdb_req_ctrl;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_CYC    = 4;
    localparam int TO_CYC      = 16;
    localparam int CNT_W       = 8;

    localparam int P_IDLE = 0;
    localparam int P_FILT = 1;
    localparam int P_REQ  = 2;
    localparam int P_ACK  = 3;
    localparam int P_REL  = 4;
    localparam int P_ERR  = 5;

    logic tclk   = 1'b0;
    logic trst_b = 1'b0;
    always #5 tclk = ~tclk;

    had_jdb_req_ctrl_if bus();

    had_jdb_req_ctrl #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYC    (FILT_CYC),
        .TO_CYC      (TO_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .tclk   (tclk),
        .trst_b (trst_b),
        .jdb    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: which protocol phase we are in, how long we have been there, and the pad as the
    // controller sees it (the pad value from SYNC_STAGES edges ago).
    int m_ph;
    int m_run;
    bit m_to;
    bit m_q[$];

    function automatic void model_reset();
        m_ph  = P_IDLE;
        m_run = 0;
        m_to  = 1'b0;
        m_q.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_q.push_back(1'b1);
    endfunction

    function automatic void model_edge();
        bit rs;
        bit stop;
        rs = m_q.pop_front();
        m_q.push_back(bus.pad_had_jdb_req_b);
        stop = bus.had_jdb_abort || !bus.had_jdb_ctrl_en;
        if (bus.had_jdb_abort) m_to = 1'b0;
        case (m_ph)
            P_IDLE: if (bus.had_jdb_ctrl_en && !rs) begin m_ph = P_FILT; m_run = 0; end
            P_FILT: begin
                if (stop || rs) m_ph = P_IDLE;
                else begin
                    m_run++;
                    if (m_run == FILT_CYC) begin m_ph = P_REQ; m_run = 0; end
                end
            end
            P_REQ: begin
                if (stop) m_ph = P_IDLE;
                else if (bus.iu_yy_xx_dbgon) m_ph = P_ACK;
                else begin
                    m_run++;
`ifdef HAD_JDB_TIMEOUT_EN
                    if (m_run == TO_CYC) begin m_ph = P_ERR; m_to = 1'b1; end
`endif
                end
            end
            P_ACK: if (rs) m_ph = P_REL;
            P_REL: if (!bus.iu_yy_xx_dbgon) m_ph = P_IDLE;
            P_ERR: if (stop || rs) m_ph = P_IDLE;
            default: m_ph = P_IDLE;
        endcase
    endfunction

    task automatic step();
        @(posedge tclk);
        model_edge();
        #1;
    endtask

    task automatic idle_settle();
        bus.pad_had_jdb_req_b = 1'b1;
        bus.iu_yy_xx_dbgon    = 1'b0;
        bus.had_jdb_ctrl_en   = 1'b1;
        bus.had_jdb_abort     = 1'b1;
        step();
        bus.had_jdb_abort     = 1'b0;
        repeat (8) step();
        n_cmp++;
        if (bus.had_jdb_busy !== 1'b0) begin
            n_bad++; $display("FAIL settle_busy: got %b expected 0", bus.had_jdb_busy);
        end
        n_cmp++;
        if (bus.had_jdb_timeout !== 1'b0) begin
            n_bad++; $display("FAIL settle_timeout: got %b expected 0", bus.had_jdb_timeout);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (bus.had_iu_jdb_dbgreq !== 1'b0) begin
            n_bad++; $display("FAIL reset_dbgreq: got %b expected 0", bus.had_iu_jdb_dbgreq);
        end
        n_cmp++;
        if (bus.had_pad_jdb_ack_b !== 1'b1) begin
            n_bad++; $display("FAIL reset_ack_b: got %b expected 1", bus.had_pad_jdb_ack_b);
        end
        n_cmp++;
        if (bus.had_jdb_busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.had_jdb_busy);
        end
        n_cmp++;
        if (bus.had_jdb_timeout !== 1'b0) begin
            n_bad++; $display("FAIL reset_timeout: got %b expected 0", bus.had_jdb_timeout);
        end
        trst_b = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (bus.had_jdb_busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_busy: got %b expected 0", bus.had_jdb_busy);
        end
    endtask

    task automatic test_basic();
        bit e_req, e_ack, e_busy;
        idle_settle();
        bus.pad_had_jdb_req_b = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            step();
            e_req  = (k >= 6 && k < 8);
            e_ack  = !(k >= 8 && k < 22);
            e_busy = (k >= 2 && k < 30);
            n_cmp++;
            if (bus.had_iu_jdb_dbgreq !== e_req) begin
                n_bad++; $display("FAIL basic_dbgreq t0+%0d: got %b expected %b", k, bus.had_iu_jdb_dbgreq, e_req);
            end
            n_cmp++;
            if (bus.had_pad_jdb_ack_b !== e_ack) begin
                n_bad++; $display("FAIL basic_ack_b t0+%0d: got %b expected %b", k, bus.had_pad_jdb_ack_b, e_ack);
            end
            n_cmp++;
            if (bus.had_jdb_busy !== e_busy) begin
                n_bad++; $display("FAIL basic_busy t0+%0d: got %b expected %b", k, bus.had_jdb_busy, e_busy);
            end
            if (k + 1 == 8)  bus.iu_yy_xx_dbgon    = 1'b1;
            if (k + 1 == 20) bus.pad_had_jdb_req_b = 1'b1;
            if (k + 1 == 30) bus.iu_yy_xx_dbgon    = 1'b0;
        end
    endtask

    task automatic test_glitch();
        idle_settle();
        bus.pad_had_jdb_req_b = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            step();
            n_cmp++;
            if (bus.had_iu_jdb_dbgreq !== 1'b0) begin
                n_bad++; $display("FAIL glitch_dbgreq t0+%0d: got %b expected 0", k, bus.had_iu_jdb_dbgreq);
            end
            if (k == 3) begin
                n_cmp++;
                if (bus.had_jdb_busy !== 1'b1) begin
                    n_bad++; $display("FAIL glitch_filt_busy: got %b expected 1", bus.had_jdb_busy);
                end
            end
            if (k == 12) begin
                n_cmp++;
                if (bus.had_jdb_busy !== 1'b0) begin
                    n_bad++; $display("FAIL glitch_idle_busy: got %b expected 0", bus.had_jdb_busy);
                end
            end
            if (k + 1 == 3) bus.pad_had_jdb_req_b = 1'b1;
        end
    endtask

    task automatic test_timeout();
        bit e_req, e_busy, e_to;
        idle_settle();
        bus.pad_had_jdb_req_b = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            step();
`ifdef HAD_JDB_TIMEOUT_EN
            e_req  = (k >= 6 && k < 6 + TO_CYC);
            e_busy = (k >= 2 && k < 26);
            e_to   = (k >= 6 + TO_CYC && k < 30);
`else
            e_req  = (k >= 6 && k < 30);
            e_busy = (k >= 2 && k < 30);
            e_to   = 1'b0;
`endif
            n_cmp++;
            if (bus.had_iu_jdb_dbgreq !== e_req) begin
                n_bad++; $display("FAIL timeout_dbgreq t0+%0d: got %b expected %b", k, bus.had_iu_jdb_dbgreq, e_req);
            end
            n_cmp++;
            if (bus.had_jdb_busy !== e_busy) begin
                n_bad++; $display("FAIL timeout_busy t0+%0d: got %b expected %b", k, bus.had_jdb_busy, e_busy);
            end
            n_cmp++;
            if (bus.had_jdb_timeout !== e_to) begin
                n_bad++; $display("FAIL timeout_flag t0+%0d: got %b expected %b", k, bus.had_jdb_timeout, e_to);
            end
            if (k + 1 == 24) bus.pad_had_jdb_req_b = 1'b1;
            if (k + 1 == 30) bus.had_jdb_abort     = 1'b1;
            if (k + 1 == 31) bus.had_jdb_abort     = 1'b0;
        end
    endtask

    task automatic test_abort_dbgon();
        idle_settle();
        bus.pad_had_jdb_req_b = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            step();
            if (k == 7) begin
                n_cmp++;
                if (bus.had_iu_jdb_dbgreq !== 1'b1) begin
                    n_bad++; $display("FAIL abort_pre_dbgreq: got %b expected 1", bus.had_iu_jdb_dbgreq);
                end
            end
            if (k == 8) begin
                n_cmp++;
                if (bus.had_iu_jdb_dbgreq !== 1'b0) begin
                    n_bad++; $display("FAIL abort_dbgreq: got %b expected 0", bus.had_iu_jdb_dbgreq);
                end
                n_cmp++;
                if (bus.had_jdb_busy !== 1'b0) begin
                    n_bad++; $display("FAIL abort_busy: got %b expected 0", bus.had_jdb_busy);
                end
            end
            if (k >= 8) begin
                n_cmp++;
                if (bus.had_pad_jdb_ack_b !== 1'b1) begin
                    n_bad++; $display("FAIL abort_ack_b t0+%0d: got %b expected 1", k, bus.had_pad_jdb_ack_b);
                end
            end
            if (k + 1 == 8) begin
                bus.had_jdb_abort  = 1'b1;
                bus.iu_yy_xx_dbgon = 1'b1;
            end
            if (k + 1 == 9) begin
                bus.had_jdb_abort     = 1'b0;
                bus.iu_yy_xx_dbgon    = 1'b0;
                bus.pad_had_jdb_req_b = 1'b1;
            end
        end
    endtask

    task automatic test_disable();
        bit e_ack;
        idle_settle();
        bus.pad_had_jdb_req_b = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            step();
            if (k == 6) begin
                n_cmp++;
                if (bus.had_iu_jdb_dbgreq !== 1'b1) begin
                    n_bad++; $display("FAIL dis_req_pre: got %b expected 1", bus.had_iu_jdb_dbgreq);
                end
            end
            if (k == 7) begin
                n_cmp++;
                if (bus.had_iu_jdb_dbgreq !== 1'b0 || bus.had_jdb_busy !== 1'b0) begin
                    n_bad++; $display("FAIL dis_req_idle: got dbgreq=%b busy=%b expected 0/0",
                                      bus.had_iu_jdb_dbgreq, bus.had_jdb_busy);
                end
            end
            if (k + 1 == 7) bus.had_jdb_ctrl_en = 1'b0;
        end

        idle_settle();
        bus.pad_had_jdb_req_b = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            step();
            e_ack = !(k >= 8 && k < 18);
            if (k >= 6) begin
                n_cmp++;
                if (bus.had_pad_jdb_ack_b !== e_ack) begin
                    n_bad++; $display("FAIL dis_ack_b t0+%0d: got %b expected %b", k, bus.had_pad_jdb_ack_b, e_ack);
                end
            end
            if (k + 1 == 8)  bus.iu_yy_xx_dbgon    = 1'b1;
            if (k + 1 == 10) bus.had_jdb_ctrl_en   = 1'b0;
            if (k + 1 == 16) bus.pad_had_jdb_req_b = 1'b1;
        end
    endtask

    task automatic test_reset_in_ack();
        bit e_req, e_busy;
        idle_settle();
        bus.pad_had_jdb_req_b = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            step();
            if (k + 1 == 8) bus.iu_yy_xx_dbgon = 1'b1;
        end
        n_cmp++;
        if (bus.had_pad_jdb_ack_b !== 1'b0) begin
            n_bad++; $display("FAIL rst_pre_ack_b: got %b expected 0", bus.had_pad_jdb_ack_b);
        end
        trst_b = 1'b0;
        model_reset();
        bus.iu_yy_xx_dbgon = 1'b0;
        #1;
        n_cmp++;
        if (bus.had_pad_jdb_ack_b !== 1'b1) begin
            n_bad++; $display("FAIL rst_async_ack_b: got %b expected 1", bus.had_pad_jdb_ack_b);
        end
        n_cmp++;
        if (bus.had_jdb_busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_async_busy: got %b expected 0", bus.had_jdb_busy);
        end
        #2;
        trst_b = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step();
            e_req  = (k >= 6);
            e_busy = (k >= 2);
            n_cmp++;
            if (bus.had_iu_jdb_dbgreq !== e_req) begin
                n_bad++; $display("FAIL rst_refilt_dbgreq r0+%0d: got %b expected %b", k, bus.had_iu_jdb_dbgreq, e_req);
            end
            n_cmp++;
            if (bus.had_jdb_busy !== e_busy) begin
                n_bad++; $display("FAIL rst_refilt_busy r0+%0d: got %b expected %b", k, bus.had_jdb_busy, e_busy);
            end
        end
    endtask

    task automatic test_random();
        idle_settle();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) bus.pad_had_jdb_req_b = ~bus.pad_had_jdb_req_b;
            if ($urandom_range(0, 7) == 0) bus.iu_yy_xx_dbgon    = ~bus.iu_yy_xx_dbgon;
            bus.had_jdb_ctrl_en = ($urandom_range(0, 39) != 0);
            bus.had_jdb_abort   = ($urandom_range(0, 49) == 0);
            step();
            n_cmp++;
            if (bus.had_iu_jdb_dbgreq !== (m_ph == P_REQ)) begin
                n_bad++; $display("FAIL rand_dbgreq cyc %0d: got %b expected %b", k, bus.had_iu_jdb_dbgreq, m_ph == P_REQ);
            end
            n_cmp++;
            if (bus.had_pad_jdb_ack_b !== (m_ph != P_ACK)) begin
                n_bad++; $display("FAIL rand_ack_b cyc %0d: got %b expected %b", k, bus.had_pad_jdb_ack_b, m_ph != P_ACK);
            end
            n_cmp++;
            if (bus.had_jdb_busy !== (m_ph != P_IDLE)) begin
                n_bad++; $display("FAIL rand_busy cyc %0d: got %b expected %b", k, bus.had_jdb_busy, m_ph != P_IDLE);
            end
            n_cmp++;
            if (bus.had_jdb_timeout !== m_to) begin
                n_bad++; $display("FAIL rand_timeout cyc %0d: got %b expected %b", k, bus.had_jdb_timeout, m_to);
            end
        end
    endtask

    initial begin
        bus.pad_had_jdb_req_b = 1'b1;
        bus.iu_yy_xx_dbgon    = 1'b0;
        bus.had_jdb_ctrl_en   = 1'b1;
        bus.had_jdb_abort     = 1'b0;
        model_reset();
        repeat (2) @(posedge tclk);
        #1;
        test_reset();
        test_basic();
        test_glitch();
        test_timeout();
        test_abort_dbgon();
        test_disable();
        test_reset_in_ack();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/had_jdb_req_ctrl.md
# had_jdb_req_ctrl

Sequences the external JDB debug-request handshake between the pad and the core in the HAD `tclk` domain. It synchronizes and glitch-filters `pad_had_jdb_req_b`, raises a debug request to the core, and waits for `iu_yy_xx_dbgon`. It then drives a four-phase active-low acknowledge back to the pad and blocks retrigger until the core leaves debug mode. An optional watchdog flags a core that never enters debug.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `pad_had_jdb_req_b`, minimum 2.
- `FILT_CYC`, default 4: consecutive low synchronized samples required to accept a request, minimum 1.
- `TO_CYC`, default 255: cycles in REQ before timeout, minimum 1.
- `CNT_W`, default 8: shared counter width; must hold `max(FILT_CYC, TO_CYC) - 1`.
- `tclk` in 1: HAD clock; all logic on the rising edge.
- `trst_b` in 1: asynchronous, active-low reset.
- `pad_had_jdb_req_b` in 1: external debug request, active-low, asynchronous to `tclk`.
- `iu_yy_xx_dbgon` in 1: core is in debug mode; synchronous to `tclk`.
- `had_jdb_ctrl_en` in 1: level enable from the HAD control register.
- `had_jdb_abort` in 1: one-cycle pulse; abandons a pending request and clears the error flag.
- `had_iu_jdb_dbgreq` out 1: debug request to the core.
- `had_pad_jdb_ack_b` out 1: active-low acknowledge to the pad.
- `had_jdb_busy` out 1: state is not IDLE.
- `had_jdb_timeout` out 1: sticky timeout error flag.
- Clocking and reset: one clock; reset is asynchronous and active-low (`tclk`, `trst_b`).

## Operation
- `req_s` is the output of the `SYNC_STAGES`-deep flop chain. All chain flops reset to 1.
- One `CNT_W`-bit counter is cleared on every state change.
- The state register is one-hot or binary (implementer's choice). All outputs are registered and decoded from the next state:
  - `had_iu_jdb_dbgreq` = 1 iff state == REQ.
  - `had_pad_jdb_ack_b` = 0 iff state == ACK.
  - `had_jdb_busy` = 1 iff state != IDLE.
- IDLE: `had_jdb_ctrl_en` && !`req_s` -> FILT.
- FILT:
  - `req_s` == 1 -> IDLE (glitch rejected).
  - Otherwise the counter increments. When count == `FILT_CYC`-1 and `req_s` == 0 -> REQ.
- REQ:
  - `iu_yy_xx_dbgon` -> ACK.
  - Otherwise the counter increments. When count == `TO_CYC`-1 -> ERR and `had_jdb_timeout` is set.
- ACK: holds while `req_s` == 0. `req_s` == 1 -> WAIT_REL.
- WAIT_REL: `iu_yy_xx_dbgon` == 0 -> IDLE. No new request is accepted here.
- ERR: `req_s` == 1 -> IDLE. `had_jdb_timeout` remains set.
- Abort: `had_jdb_abort` in FILT, REQ or ERR -> IDLE. In ACK and WAIT_REL it has no effect on state. In every state it clears `had_jdb_timeout`.
- Priority of abort: it wins over a simultaneous `iu_yy_xx_dbgon` in REQ (-> IDLE). It also wins over a same-cycle timeout set; the flag stays 0.
- Disable: `had_jdb_ctrl_en` == 0 forces FILT, REQ or ERR -> IDLE. ACK and WAIT_REL always complete normally so the pad handshake is never broken.
- Reset values: state IDLE, counter 0, `had_iu_jdb_dbgreq` 0, `had_pad_jdb_ack_b` 1, `had_jdb_busy` 0, `had_jdb_timeout` 0.
- Reset mid-operation returns to these values immediately (asynchronous assertion). Release is synchronous to the next `tclk` edge.

## Timing
- The pad falls before edge t0 and is captured at t0.
- With `SYNC_STAGES`=2, `req_s` is low after t0+1, and FILT is entered at t0+2.
- REQ is entered at t0+2+`FILT_CYC`: t0+6 with defaults. `had_iu_jdb_dbgreq` is high from that edge.
- `iu_yy_xx_dbgon` high at edge e gives ACK at e, with `had_pad_jdb_ack_b` low after e. Latency is 1 cycle.
- The pad release takes `SYNC_STAGES` cycles to reach `req_s`. `had_pad_jdb_ack_b` returns to 1 on the edge where `req_s` is sampled high.
- Timeout: ERR is entered on the `TO_CYC`-th edge after REQ entry. `had_jdb_timeout` rises on that same edge.

## Configuration
- Macro: `HAD_JDB_TIMEOUT_EN`.
- Defined: REQ timeout, ERR state and `had_jdb_timeout` operate as described above.
- Undefined:
  - REQ waits indefinitely for `iu_yy_xx_dbgon` or abort/disable.
  - ERR is not implemented.
  - `had_jdb_timeout` is tied to 0.
  - The counter is used only for FILT, and `TO_CYC` is ignored.

## Test plan
- Basic handshake: pad low at t0, `dbgon` = 1 at t0+8, pad high at t0+20, `dbgon` = 0 at t0+30.
  - Required: `dbgreq` high t0+6..t0+8, `ack_b` low t0+8..t0+22, `busy` drops at t0+30.
- Glitch: pad low for 3 cycles (synchronized), defaults -> `dbgreq` never asserts; state returns to IDLE.
- Timeout (macro on, `TO_CYC`=16): request with `dbgon` held 0.
  - Required: `dbgreq` drops and `timeout` = 1 exactly 16 cycles after REQ entry.
  - Pad release -> IDLE with `timeout` still 1. An abort pulse then clears it.
- Abort coincident with `dbgon` in REQ -> IDLE, `ack_b` stays 1, `dbgreq` = 0 next cycle.
- Disable mid-operation:
  - `en` = 0 in REQ -> IDLE next edge.
  - `en` = 0 in ACK -> `ack_b` stays low until the pad releases.
- Reset: `trst_b` low while in ACK -> `ack_b` = 1, `busy` = 0 immediately (asynchronous). After release, a held-low pad re-runs FILT (REQ at +`FILT_CYC` from FILT entry).
